// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR over WIDTH bits, SLICE bits per clock.
// Uses a start/busy/done handshake and registers a zero flag alongside each completed result.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             busy,
    output logic             done,
    output logic             isZero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_isZero;

    logic [SLICE-1:0] w_sliceA;
    logic [SLICE-1:0] w_sliceB;
    logic [SLICE-1:0] w_slice;
    logic [WIDTH-1:0] w_nextResult;
    logic             w_last;
    logic             w_accept;

    // A single SLICE-wide function unit is shared; the counter steers operands into it.
    always_comb begin
        w_sliceA = '0;
        w_sliceB = '0;
        for (int s = 0; s < N; s++) begin
            if (r_count == CW'(s)) begin
                w_sliceA = r_opA[s*SLICE +: SLICE];
                w_sliceB = r_opB[s*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        w_slice = '0;
        case (r_op)
            2'b00:   w_slice = w_sliceA & w_sliceB;
            2'b01:   w_slice = w_sliceA | w_sliceB;
            2'b10:   w_slice = w_sliceA ^ w_sliceB;
            default: w_slice = ~(w_sliceA | w_sliceB);
        endcase
    end

    for (genvar g = 0; g < N; g++) begin : g_merge
        assign w_nextResult[g*SLICE +: SLICE] =
            (r_count == CW'(g)) ? w_slice : r_result[g*SLICE +: SLICE];
    end

    assign w_last   = (r_count == CW'(N - 1));
    // Requests arriving mid-operation are dropped, not queued.
    assign w_accept = start && (r_state != RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_op     <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_isZero <= 1'b0;
        end else if (w_accept) begin
            r_state  <= RUN;
            r_count  <= '0;
            r_op     <= op;
            r_opA    <= data_operandA;
            r_opB    <= data_operandB;
            r_result <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_isZero <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_result <= w_nextResult;
                    if (w_last) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_isZero <= (w_nextResult == '0);
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result = r_result;
    assign busy        = r_busy;
    assign done        = r_done;
    assign isZero      = r_isZero;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: table vectors, random ops against a whole-word reference,
// handshake corner cases, and a parameter sweep over several WIDTH/SLICE instances.
module tb_logic_unit_seq;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        isZero;

    logic        swStart;
    logic [1:0]  swOp;
    logic [63:0] swA;
    logic [63:0] swB;
    logic [31:0] res32_32;
    logic [31:0] res32_1;
    logic [31:0] res32_16;
    logic [63:0] res64_8;
    logic [3:0]  swBusy;
    logic [3:0]  swDone;
    logic [3:0]  swZero;

    int errors = 0;
    int checks = 0;
    int overlapCount = 0;
    int cycleCount = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
        logic        expZero;
    } vec_t;

    vec_t vecs[4];

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .data_operandA(dataA), .data_operandB(dataB),
        .data_result(result), .busy(busy), .done(done), .isZero(isZero)
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(32)) dut32_32 (
        .clock(clock), .reset(reset), .start(swStart), .op(swOp),
        .data_operandA(swA[31:0]), .data_operandB(swB[31:0]),
        .data_result(res32_32), .busy(swBusy[0]), .done(swDone[0]), .isZero(swZero[0])
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(1)) dut32_1 (
        .clock(clock), .reset(reset), .start(swStart), .op(swOp),
        .data_operandA(swA[31:0]), .data_operandB(swB[31:0]),
        .data_result(res32_1), .busy(swBusy[1]), .done(swDone[1]), .isZero(swZero[1])
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(16)) dut32_16 (
        .clock(clock), .reset(reset), .start(swStart), .op(swOp),
        .data_operandA(swA[31:0]), .data_operandB(swB[31:0]),
        .data_result(res32_16), .busy(swBusy[2]), .done(swDone[2]), .isZero(swZero[2])
    );

    logic_unit_seq #(.WIDTH(64), .SLICE(8)) dut64_8 (
        .clock(clock), .reset(reset), .start(swStart), .op(swOp),
        .data_operandA(swA), .data_operandB(swB),
        .data_result(res64_8), .busy(swBusy[3]), .done(swDone[3]), .isZero(swZero[3])
    );

    always @(posedge clock) cycleCount <= cycleCount + 1;

    always @(negedge clock) begin
        if ((busy && done) || ((swBusy & swDone) != 4'b0)) overlapCount <= overlapCount + 1;
    end

    function automatic logic [63:0] refOp(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = s;
        op    = o;
        dataA = a;
        dataB = b;
    endtask

    task automatic waitDone(output int lat, output int busyCycles);
        lat = 0;
        busyCycles = 0;
        while (!done && lat < 64) begin
            if (busy) busyCycles++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expR, input logic expZ);
        int lat;
        int bc;
        applyStimulus(1'b1, o, a, b);
        @(negedge clock);
        applyStimulus(1'b0, o, a, b);
        waitDone(lat, bc);
        checkOutput({name, " latency"}, 64'(lat), 64'd4);
        checkOutput({name, " busy cycles"}, 64'(bc), 64'd4);
        checkOutput({name, " result"}, {32'b0, result}, {32'b0, expR});
        checkOutput({name, " isZero"}, {63'b0, isZero}, {63'b0, expZ});
        @(negedge clock);
        checkOutput({name, " done pulse width"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int doneCount;
        int busyCount;
        int lastDone;
        logic [1:0]  bo[3];
        logic [31:0] ba[3];
        logic [31:0] bb[3];
        logic [63:0] expW;

        vecs[0] = '{2'd0, 32'h12345678, 32'h87654321, 32'h02244220, 1'b0};
        vecs[1] = '{2'd1, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 1'b0};
        vecs[2] = '{2'd2, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0};
        vecs[3] = '{2'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1};

        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 32'h0, 32'h0);
        swStart = 1'b0; swOp = 2'd0; swA = '0; swB = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset result", {32'b0, result}, 64'd0);
        checkOutput("reset busy", {63'b0, busy}, 64'd0);
        checkOutput("reset done", {63'b0, done}, 64'd0);
        checkOutput("reset isZero", {63'b0, isZero}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 4; i++)
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expResult, vecs[i].expZero);

        // Last vector was NOR with a zero result; it must persist through idle cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("hold result", {32'b0, result}, {32'b0, vecs[3].expResult});
            checkOutput("hold isZero", {63'b0, isZero}, {63'b0, vecs[3].expZero});
            checkOutput("hold done", {63'b0, done}, 64'd0);
        end

        for (int i = 0; i < 16; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 5 == 0) ? ~ra : $urandom;
            expW = refOp(ro, {32'b0, ra}, {32'b0, rb});
            runOp($sformatf("rand%0d", i), ro, ra, rb, expW[31:0], expW[31:0] == 32'b0);
        end

        // Start pulse and operand changes during RUN must not disturb the current op.
        applyStimulus(1'b1, 2'd0, 32'hFFFFFFFF, 32'h88888888);
        @(negedge clock);
        applyStimulus(1'b0, 2'd0, 32'hFFFFFFFF, 32'h88888888);
        @(negedge clock);
        applyStimulus(1'b1, 2'd1, 32'h0, 32'h0);
        @(negedge clock);
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0);
        waitDone(lat, bc);
        checkOutput("ignore latency", 64'(lat), 64'd2);
        checkOutput("ignore result", {32'b0, result}, 64'h88888888);
        doneCount = 0;
        busyCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) doneCount++;
            if (busy) busyCount++;
        end
        checkOutput("ignore extra done", 64'(doneCount), 64'd0);
        checkOutput("ignore extra busy", 64'(busyCount), 64'd0);

        // Back-to-back accepts with start held high.
        bo[0] = 2'd0; ba[0] = 32'hA5A5A5A5; bb[0] = 32'h0F0F0F0F;
        bo[1] = 2'd1; ba[1] = 32'h12340000; bb[1] = 32'h00005678;
        bo[2] = 2'd2; ba[2] = 32'hFFFF0000; bb[2] = 32'hFF00FF00;
        applyStimulus(1'b1, bo[0], ba[0], bb[0]);
        @(negedge clock);
        lastDone = 0;
        for (int k = 0; k < 3; k++) begin
            waitDone(lat, bc);
            expW = refOp(bo[k], {32'b0, ba[k]}, {32'b0, bb[k]});
            checkOutput($sformatf("b2b%0d result", k), {32'b0, result}, expW);
            if (k == 0) checkOutput("b2b0 latency", 64'(lat), 64'd4);
            else checkOutput($sformatf("b2b%0d gap", k), 64'(cycleCount - lastDone), 64'd5);
            lastDone = cycleCount;
            if (k < 2) applyStimulus(1'b1, bo[k+1], ba[k+1], bb[k+1]);
            else applyStimulus(1'b0, bo[k], ba[k], bb[k]);
            @(negedge clock);
        end
        checkOutput("b2b idle busy", {63'b0, busy}, 64'd0);
        checkOutput("b2b idle done", {63'b0, done}, 64'd0);

        // Reset during RUN abandons the operation.
        applyStimulus(1'b1, 2'd0, 32'h01234567, 32'h89ABCDEF);
        @(negedge clock);
        applyStimulus(1'b0, 2'd0, 32'h01234567, 32'h89ABCDEF);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset result", {32'b0, result}, 64'd0);
        checkOutput("midreset busy", {63'b0, busy}, 64'd0);
        checkOutput("midreset done", {63'b0, done}, 64'd0);
        checkOutput("midreset isZero", {63'b0, isZero}, 64'd0);
        reset = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done) doneCount++;
        end
        checkOutput("midreset no done", 64'(doneCount), 64'd0);
        runOp("after reset", 2'd0, 32'h01234567, 32'h89ABCDEF, 32'h01234567, 1'b0);

        // Parameter sweep across several slice widths.
        for (int v = 0; v < 4; v++) begin
            int swLat[4];
            logic [63:0] swRes[4];
            logic swZ[4];
            int expLat[4];
            logic [63:0] expR;
            expLat = '{1, 32, 2, 8};
            swOp = vecs[v].op;
            swA  = {vecs[v].b, vecs[v].a};
            swB  = {vecs[v].a, vecs[v].b};
            swStart = 1'b1;
            @(negedge clock);
            swStart = 1'b0;
            for (int i = 0; i < 4; i++) begin
                swLat[i] = -1;
                swRes[i] = '0;
                swZ[i]   = 1'b0;
            end
            for (int c = 0; c < 40; c++) begin
                for (int i = 0; i < 4; i++) begin
                    if (swDone[i] && swLat[i] < 0) begin
                        swLat[i] = c;
                        swZ[i]   = swZero[i];
                        case (i)
                            0:       swRes[i] = {32'b0, res32_32};
                            1:       swRes[i] = {32'b0, res32_1};
                            2:       swRes[i] = {32'b0, res32_16};
                            default: swRes[i] = res64_8;
                        endcase
                    end
                end
                @(negedge clock);
            end
            for (int i = 0; i < 4; i++) begin
                expR = refOp(swOp, swA, swB);
                if (i < 3) expR = expR & 64'h00000000FFFFFFFF;
                checkOutput($sformatf("sweep v%0d i%0d latency", v, i), 64'(swLat[i]), 64'(expLat[i]));
                checkOutput($sformatf("sweep v%0d i%0d result", v, i), swRes[i], expR);
                checkOutput($sformatf("sweep v%0d i%0d isZero", v, i), {63'b0, swZ[i]}, {63'b0, expR == 64'b0});
            end
        end

        checkOutput("busy/done overlap", 64'(overlapCount), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised, multi-cycle bitwise logic unit for the ALU datapath. It generalises the single-cycle 32-bit AND to a selectable operation (AND/OR/XOR/NOR) at configurable operand width. The result is processed SLICE bits per clock to trade latency for area. A start/busy/done handshake connects it to the ALU control, and it raises a registered zero flag with each result.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 8, bits computed per clock; N = WIDTH/SLICE slice cycles per operation.
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a rising edge when the unit is not busy.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- data_operandA  input  WIDTH  first operand, latched on accepted start.
- data_operandB  input  WIDTH  second operand, latched on accepted start.
- data_result  output  WIDTH  result register.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse; data_result and isZero are valid.
- isZero  output  1  high when the completed data_result == 0.

## Operation
- Reset values: all outputs 0; state IDLE; slice counter 0; operand/op latches 0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE to RUN: start=1 at an edge. That edge latches A, B and op, clears data_result to 0, and sets counter = 0.
- RUN: each edge writes slice i = counter: data_result[i*SLICE +: SLICE] = f(A_lat, B_lat) over those bits, then counter increments.
  - When counter == N-1 at the edge, that edge writes the final slice and moves to DONE.
  - isZero is registered from the fully assembled result on the same edge.
- DONE to IDLE: next edge when start=0.
- DONE to RUN: next edge when start=1. This is a back-to-back accept with the same actions as IDLE to RUN, and done drops.
- start while in RUN is ignored: no latch, no effect on the current operation, no queued request.
- Changes on data_operandA, data_operandB or op after the accepting edge have no effect on the current operation.
- data_result and isZero hold their values from DONE through IDLE until the next accepted start clears them.
- During RUN, data_result shows only partially written slices; consumers use it only when done=1 or in IDLE after a done.
- NOR is ~(A|B) per bit. No carries cross slice boundaries, so slice order does not affect the value.
- reset=1 at any edge, including mid-RUN or in DONE: return to the reset values and abandon the operation. Reset has priority over start on the same edge.

## Timing
- Accept edge E0: start=1 while in IDLE or DONE.
- busy is high after edges E0 .. E(N-1), which is N cycles.
- done is high for exactly one cycle, after edge E(N). Latency from accept to done is N clocks: 4 for the defaults, 1 when SLICE=WIDTH.
- busy and done are never high together.
- Maximum throughput: one operation per N+1 clocks with start held high. A new accept can land on the DONE cycle, so there are no idle gaps.

## Test plan
- AND, A=0x12345678, B=0x87654321, single start pulse -> busy high 4 cycles, then done for 1 cycle with data_result=0x02244220 and isZero=0.
- OR 0x0000FFFF|0xFFFF0000 -> 0xFFFFFFFF. XOR 0xAAAAAAAA^0xFFFFFFFF -> 0x55555555. NOR 0xF0F0F0F0,0x0F0F0F0F -> 0x00000000 with isZero=1.
  - Hold results through 3 IDLE cycles and check they are unchanged.
- Start AND 0xFFFFFFFF&0x88888888, then during RUN change the operands to 0 and pulse start again.
  - Required: a single done, data_result=0x88888888, and no second operation.
- start held high for 3 operations with different operands -> done every 5th cycle, each result correct, busy never high while done is high.
- Assert reset at RUN cycle 2 of 0x01234567&0x89ABCDEF -> next cycle all outputs 0 and no done.
  - A subsequent start then gives 0x01234567 in 4 cycles.
- Parameter sweep WIDTH=32 with SLICE=32, 1 and 16, and WIDTH=64 with SLICE=8, running the AND, OR, XOR and NOR vectors above.
  - Required latencies: 1, 32, 2 and 8 clocks, with results matching a bitwise reference model.
